// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: instruction constants, reset PC default
// and the IF/ID payload layout seen by the decode stage.
package mips_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned INSTR_BYTES = 4;

   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // IF/ID pipeline register payload as consumed by ID
   typedef struct packed {
      logic [XLEN-1:0] pc4;
      logic [XLEN-1:0] instr;
      logic            valid;
   } if_id_t;

endpackage : mips_pkg

// File: rtl/pc_register.sv
// Program counter flop with next-PC selection: redirect beats stall beats
// sequential increment. Also exports the combinational PC+4 for IF/ID.
module pc_register
   import mips_pkg::*;
#(
   parameter int unsigned         ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              branch_taken_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] pc4_c
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   // increment wraps naturally at 2^ADDR_W
   assign pc4_c = pc_q + ADDR_W'(INSTR_BYTES);
   assign pc_o  = pc_q;

   always_comb begin
      pc_d = pc4_c;
      if (branch_taken_i) begin
         pc_d = {branch_target_i[ADDR_W-1:2], 2'b00};
      end else if (stall_i) begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule : pc_register

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, presents it to instruction memory and latches the
// returned word into the IF/ID register, honouring stall and flush.
module fetch_stage
   import mips_pkg::*;
#(
   parameter int unsigned         ADDR_W   = 32,
   parameter int unsigned         DATA_W   = 32,
   parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              branch_taken_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic [DATA_W-1:0] imem_data_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] if_id_pc4_o,
   output logic [DATA_W-1:0] if_id_instr_o,
   output logic              if_id_valid_o
);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc4;

   pc_register #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .pc_o            (pc),
      .pc4_c           (pc4)
   );

   // memory address is the PC itself, no extra cycle
   assign imem_addr_o = pc;
   assign pc_o        = pc;

   // IF/ID register: flush beats stall beats capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_id_pc4_o   <= '0;
         if_id_instr_o <= DATA_W'(NOP_INSTR);
         if_id_valid_o <= 1'b0;
      end else if (flush_i) begin
         if_id_pc4_o   <= '0;
         if_id_instr_o <= DATA_W'(NOP_INSTR);
         if_id_valid_o <= 1'b0;
      end else if (!stall_i) begin
         if_id_pc4_o   <= pc4;
         if_id_instr_o <= imem_data_i;
         if_id_valid_o <= 1'b1;
      end
   end

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/flush/branch traffic against a cycle-level reference model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0, flush = 1'b0, br = 1'b0;
   logic [31:0] tgt = '0;
   logic [31:0] imem_addr, imem_data, pc, pc4, instr;
   logic        valid;

   logic        stall2 = 1'b0, flush2 = 1'b0, br2 = 1'b0;
   logic [31:0] tgt2 = '0;
   logic [31:0] imem_addr2, imem_data2, pc_2, pc4_2, instr_2;
   logic        valid_2;

   logic [31:0] imem [64];

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [31:0] m_pc, m_pc4, m_instr;
   logic        m_valid;

   always #5 clk = ~clk;

   assign imem_data  = imem[imem_addr[7:2]];
   assign imem_data2 = imem[imem_addr2[7:2]];

   fetch_stage dut (
      .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
      .branch_taken_i(br), .branch_target_i(tgt),
      .imem_addr_o(imem_addr), .imem_data_i(imem_data), .pc_o(pc),
      .if_id_pc4_o(pc4), .if_id_instr_o(instr), .if_id_valid_o(valid)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst(rst), .stall_i(stall2), .flush_i(flush2),
      .branch_taken_i(br2), .branch_target_i(tgt2),
      .imem_addr_o(imem_addr2), .imem_data_i(imem_data2), .pc_o(pc_2),
      .if_id_pc4_o(pc4_2), .if_id_instr_o(instr_2), .if_id_valid_o(valid_2)
   );

   function automatic logic [128:0] dut_vec();
      return {imem_addr, pc, pc4, instr, valid};
   endfunction

   function automatic logic [128:0] exp_vec(input logic [31:0] p, input logic [31:0] p4,
                                            input logic [31:0] ins, input logic v);
      return {p, p, p4, ins, v};
   endfunction

   // drive one cycle of inputs, advance the model by one edge, sample after the edge
   task automatic step(input logic b, input logic s, input logic f, input logic [31:0] t);
      logic [31:0] nxt_pc;
      br = b; stall = s; flush = f; tgt = t;
      if (b)      nxt_pc = t & 32'hFFFF_FFFC;
      else if (s) nxt_pc = m_pc;
      else        nxt_pc = m_pc + 32'd4;
      if (f) begin
         m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (!s) begin
         m_instr = imem[m_pc[7:2]]; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end
      m_pc = nxt_pc;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      br = 0; stall = 0; flush = 0; tgt = '0;
      rst = 1'b1;
      m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (dut_vec() !== exp_vec(32'h0, 32'h0, 32'h0, 1'b0)) begin
         errors++; $display("FAIL reset_async got=%h exp=%h", dut_vec(), exp_vec(32'h0, 32'h0, 32'h0, 1'b0));
      end
      m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (dut_vec() !== exp_vec(32'h0, 32'h0, 32'h0, 1'b0)) begin
         errors++; $display("FAIL reset_release got=%h exp=%h", dut_vec(), exp_vec(32'h0, 32'h0, 32'h0, 1'b0));
      end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_i [3];
      exp_i[0] = 32'h0109_5020; exp_i[1] = 32'hAC0A_0000; exp_i[2] = 32'h0149_5822;
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, '0);
         checks++;
         if (dut_vec() !== exp_vec(32'(4*(k+1)), 32'(4*(k+1)), exp_i[k], 1'b1)) begin
            errors++; $display("FAIL seq_%0d got=%h exp=%h", k, dut_vec(),
                               exp_vec(32'(4*(k+1)), 32'(4*(k+1)), exp_i[k], 1'b1));
         end
      end
   endtask

   task automatic test_stall();
      for (int k = 0; k < 2; k++) begin
         step(0, 1, 0, '0);
         checks++;
         if (dut_vec() !== exp_vec(32'hC, 32'hC, 32'h0149_5822, 1'b1)) begin
            errors++; $display("FAIL stall_hold_%0d got=%h exp=%h", k, dut_vec(),
                               exp_vec(32'hC, 32'hC, 32'h0149_5822, 1'b1));
         end
      end
      step(0, 0, 0, '0);
      checks++;
      if (dut_vec() !== exp_vec(32'h10, 32'h10, 32'h8C6A_0003, 1'b1)) begin
         errors++; $display("FAIL stall_release got=%h exp=%h", dut_vec(), exp_vec(32'h10, 32'h10, 32'h8C6A_0003, 1'b1));
      end
   endtask

   task automatic test_branch();
      step(0, 0, 0, '0);
      checks++;
      if (dut_vec() !== exp_vec(32'h14, 32'h14, 32'h014A_5020, 1'b1)) begin
         errors++; $display("FAIL pre_branch got=%h exp=%h", dut_vec(), exp_vec(32'h14, 32'h14, 32'h014A_5020, 1'b1));
      end
      step(1, 0, 1, 32'h4);
      checks++;
      if (dut_vec() !== exp_vec(32'h4, 32'h0, 32'h0, 1'b0)) begin
         errors++; $display("FAIL branch_bubble got=%h exp=%h", dut_vec(), exp_vec(32'h4, 32'h0, 32'h0, 1'b0));
      end
      step(0, 0, 0, '0);
      checks++;
      if (dut_vec() !== exp_vec(32'h8, 32'h8, 32'hAC0A_0000, 1'b1)) begin
         errors++; $display("FAIL branch_target got=%h exp=%h", dut_vec(), exp_vec(32'h8, 32'h8, 32'hAC0A_0000, 1'b1));
      end
   endtask

   task automatic test_stall_flush();
      step(0, 1, 1, 32'h40);
      checks++;
      if (dut_vec() !== exp_vec(32'h8, 32'h0, 32'h0, 1'b0)) begin
         errors++; $display("FAIL stall_flush got=%h exp=%h", dut_vec(), exp_vec(32'h8, 32'h0, 32'h0, 1'b0));
      end
      step(1, 1, 1, 32'h7);
      checks++;
      if (dut_vec() !== exp_vec(32'h4, 32'h0, 32'h0, 1'b0)) begin
         errors++; $display("FAIL stall_flush_branch got=%h exp=%h", dut_vec(), exp_vec(32'h4, 32'h0, 32'h0, 1'b0));
      end
      // branch without flush: redirect while IF/ID captures the word at pc=4
      step(1, 0, 0, 32'h10);
      checks++;
      if (dut_vec() !== exp_vec(32'h10, 32'h8, 32'hAC0A_0000, 1'b1)) begin
         errors++; $display("FAIL branch_noflush got=%h exp=%h", dut_vec(), exp_vec(32'h10, 32'h8, 32'hAC0A_0000, 1'b1));
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      #1;
      checks++;
      if ({pc_2, imem_addr2, valid_2} !== {32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0}) begin
         errors++; $display("FAIL wrap_reset got pc=%h addr=%h v=%b exp pc=fffffffc", pc_2, imem_addr2, valid_2);
      end
      step(0, 0, 0, '0);
      checks++;
      if ({pc_2, pc4_2, instr_2, valid_2} !== {32'h0, 32'h0, imem[63], 1'b1}) begin
         errors++; $display("FAIL wrap_edge got pc=%h pc4=%h ins=%h v=%b exp pc=0 pc4=0 ins=%h v=1",
                            pc_2, pc4_2, instr_2, valid_2, imem[63]);
      end
   endtask

   task automatic test_reset_midstall();
      apply_reset();
      step(0, 0, 0, '0);
      step(0, 0, 0, '0);
      step(0, 1, 0, '0);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (dut_vec() !== exp_vec(32'h0, 32'h0, 32'h0, 1'b0)) begin
         errors++; $display("FAIL reset_midstall got=%h exp=%h", dut_vec(), exp_vec(32'h0, 32'h0, 32'h0, 1'b0));
      end
      m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0; stall = 1'b0;
      step(0, 0, 0, '0);
      checks++;
      if (dut_vec() !== exp_vec(32'h4, 32'h4, 32'h0109_5020, 1'b1)) begin
         errors++; $display("FAIL resume_after_reset got=%h exp=%h", dut_vec(), exp_vec(32'h4, 32'h4, 32'h0109_5020, 1'b1));
      end
   endtask

   task automatic test_random();
      logic        b, s, f;
      logic [31:0] t;
      for (int k = 0; k < 400; k++) begin
         b = ($urandom_range(0, 5) == 0);
         s = ($urandom_range(0, 3) == 0);
         f = b ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
         t = 32'($urandom_range(0, 255));
         step(b, s, f, t);
         checks++;
         if (dut_vec() !== exp_vec(m_pc, m_pc4, m_instr, m_valid)) begin
            errors++; $display("FAIL random_%0d b=%b s=%b f=%b got=%h exp=%h", k, b, s, f,
                               dut_vec(), exp_vec(m_pc, m_pc4, m_instr, m_valid));
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) imem[i] = $urandom;
      imem[0] = 32'h0109_5020; imem[1] = 32'hAC0A_0000; imem[2] = 32'h0149_5822;
      imem[3] = 32'h8C6A_0003; imem[4] = 32'h014A_5020; imem[5] = 32'h1168_FFFC;
      m_pc = '0; m_pc4 = '0; m_instr = '0; m_valid = 1'b0;

      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_stall_flush();
      test_wrap();
      test_reset_midstall();
      apply_reset();
      test_random();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fetch_stage
